// File: rtl/flow_pkg.sv
// Shared defaults for the flow datapath stages (converters and FIFO).
// Provides the default data width, FIFO depth and a constant clog2 helper.
package flow_pkg;

   localparam int FLOW_DATAW = 8;
   localparam int FLOW_DEPTH = 8;

   // Constant function usable in parameter expressions; clog2(1) returns 0.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/flow_fifo_ram.sv
// DEPTH x DATAW storage for flow_fifo_vldrdy: one synchronous write port and
// an asynchronous read port, so the FIFO head is visible in the same cycle.
module flow_fifo_ram
   import flow_pkg::*;
#(
   parameter int DATAW = FLOW_DATAW,
   parameter int DEPTH = FLOW_DEPTH,
   localparam int ADDRW = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [ADDRW-1:0] wr_addr,
   input  logic [DATAW-1:0] wr_data,
   input  logic [ADDRW-1:0] rd_addr,
   output logic [DATAW-1:0] rd_data
);

   // Contents are never reset; the FIFO only reads entries it has written.
   logic [DATAW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/flow_fifo_vldrdy.sv
// Elastic first-word-fall-through valid/ready FIFO between the 16-to-8 converter
// and the sink. Define FLOW_FIFO_VLDRDY_CNT_EN to add in_cnt/out_cnt handshake counters.
module flow_fifo_vldrdy
   import flow_pkg::*;
#(
   parameter int DATAW = FLOW_DATAW,
   parameter int DEPTH = FLOW_DEPTH,
   localparam int ADDRW = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_en,
   input  logic             src_val,
   output logic             src_rdy,
   input  logic [DATAW-1:0] src_data,
   output logic             dst_val,
   input  logic             dst_rdy,
   output logic [DATAW-1:0] dst_data,
   output logic [ADDRW:0]   level,
   output logic             full,
   output logic             empty
`ifdef FLOW_FIFO_VLDRDY_CNT_EN
   ,
   output logic [31:0]      in_cnt,
   output logic [31:0]      out_cnt
`endif
);

   localparam logic [ADDRW:0] LEVEL_MAX = (ADDRW + 1)'(DEPTH);

   logic [ADDRW-1:0] wr_ptr_reg;
   logic [ADDRW-1:0] rd_ptr_reg;
   logic [ADDRW:0]   level_reg;
   logic [ADDRW:0]   level_next;
   logic [DATAW-1:0] rd_data;
   logic             push;
   logic             pop;

   // Handshake outputs depend only on state, cfg_en and rst, never on the
   // partner's valid/ready, so a full FIFO refuses even when a pop is pending.
   assign full    = (level_reg == LEVEL_MAX);
   assign empty   = (level_reg == '0);
   assign src_rdy = cfg_en & ~full & ~rst;
   assign dst_val = cfg_en & ~empty & ~rst;
   assign push    = src_val & src_rdy;
   assign pop     = dst_val & dst_rdy;
   assign level   = level_reg;

   assign dst_data = dst_val ? rd_data : '0;

   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase
   end

   // DEPTH is a power of two, so the pointers wrap naturally at DEPTH-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         level_reg <= level_next;
      end
   end

   flow_fifo_ram #(
      .DATAW (DATAW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_reg),
      .wr_data (src_data),
      .rd_addr (rd_ptr_reg),
      .rd_data (rd_data)
   );

`ifdef FLOW_FIFO_VLDRDY_CNT_EN
   logic [31:0] in_cnt_reg;
   logic [31:0] out_cnt_reg;

   // Counters wrap at 2^32, keeping in_cnt - out_cnt == level modulo 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_cnt_reg  <= '0;
         out_cnt_reg <= '0;
      end else begin
         if (push) begin
            in_cnt_reg <= in_cnt_reg + 32'd1;
         end
         if (pop) begin
            out_cnt_reg <= out_cnt_reg + 32'd1;
         end
      end
   end

   assign in_cnt  = in_cnt_reg;
   assign out_cnt = out_cnt_reg;
`endif

endmodule
